// File: rtl/if_stage_pkg.sv
// ============================================================================
// Module   : if_stage_pkg
// Brief    : Shared constants, fetch FSM encoding and queue entry type for IF.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package if_stage_pkg;

    localparam logic [31:0] c_nop      = 32'h0000_0013;
    localparam logic [31:0] c_reset_pc = 32'h0000_0000;

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        DROP  = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fq_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

`default_nettype wire

// File: rtl/if_stage_if.sv
// ============================================================================
// Module   : if_stage_if
// Brief    : Instruction-memory, decode and redirect signals of the IF stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface if_stage_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall_ID;
    logic        br_taken_EX;
    logic [31:0] br_target_EX;
    logic [31:0] IR_IF;
    logic [31:0] PC_IF;
    logic [31:0] PC4_IF;
    logic        valid_IF;

    modport master (
        output imem_req, imem_addr, IR_IF, PC_IF, PC4_IF, valid_IF,
        input  imem_ack, imem_rdata, stall_ID, br_taken_EX, br_target_EX
    );

    modport slave (
        input  imem_req, imem_addr, IR_IF, PC_IF, PC4_IF, valid_IF,
        output imem_ack, imem_rdata, stall_ID, br_taken_EX, br_target_EX
    );

endinterface

`default_nettype wire

// File: rtl/if_stage_fetch_queue.sv
// ============================================================================
// Module   : if_stage_fetch_queue
// Brief    : Synchronous FIFO of {pc, inst}; flush wins over push and pop.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_stage_fetch_queue #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  wire logic                     clk,
    input  wire logic                     rst,
    input  wire logic                     push,
    input  wire logic                     pop,
    input  wire logic                     flush,
    input  wire logic [WIDTH-1:0]         wdata,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(DEPTH):0]        count,
    output logic [WIDTH-1:0]              head
);

    localparam int c_aw = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_aw:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_count == (c_aw+1)'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign head      = r_mem[r_rd_ptr];
    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; stale slots are never visible because of count.
    always_ff @(posedge clk) begin
        if (!rst && !flush && w_do_push) r_mem[r_wr_ptr] <= wdata;
    end

endmodule

`default_nettype wire

// File: rtl/if_stage.sv
// ============================================================================
// Module   : if_stage
// Brief    : RV32I fetch stage: PC, req/ack imem fetch, fetch queue, redirects.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = c_reset_pc,
    parameter int          FQ_DEPTH = 2
) (
    input  wire logic     clk,
    input  wire logic     rst,
    if_stage_if.master    bus
);

    localparam int c_cw = $clog2(FQ_DEPTH) + 1;

    fetch_state_t      r_state;
    logic [31:0]       r_fetch_pc;
    logic [31:0]       r_drop_addr;
    logic              w_req;
    logic              w_xfer;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic [c_cw-1:0]   w_count;
    fq_entry_t         w_head;
    fq_entry_t         w_wentry;
    logic [31:0]       w_pc_out;

    // DROP keeps the squashed request alive so the handshake stays stable until ack.
    assign w_req  = ~rst & ((r_state == DROP) | (w_count < c_cw'(FQ_DEPTH)));
    assign w_xfer = w_req & bus.imem_ack;
    assign w_push = w_xfer & (r_state == FETCH) & ~bus.br_taken_EX & ~w_full;
    assign w_pop  = ~w_empty & ~bus.stall_ID;

    assign w_wentry = '{pc: r_fetch_pc, inst: bus.imem_rdata};

    if_stage_fetch_queue #(
        .WIDTH (64),
        .DEPTH (FQ_DEPTH)
    ) u_fetch_queue (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .flush (bus.br_taken_EX),
        .wdata (w_wentry),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count),
        .head  (w_head)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= FETCH;
            r_fetch_pc  <= RESET_PC;
            r_drop_addr <= RESET_PC;
        end else if (bus.br_taken_EX) begin
            r_fetch_pc <= word_align(bus.br_target_EX);
            if (r_state == FETCH && w_req && !bus.imem_ack) begin
                r_state     <= DROP;
                r_drop_addr <= r_fetch_pc;
            end else if (r_state == DROP && bus.imem_ack) begin
                r_state <= FETCH;
            end
        end else if (r_state == DROP) begin
            if (bus.imem_ack) r_state <= FETCH;
        end else if (w_push) begin
            r_fetch_pc <= r_fetch_pc + 32'd4;
        end
    end

    assign w_pc_out      = w_empty ? 32'h0 : w_head.pc;
    assign bus.imem_req  = w_req;
    assign bus.imem_addr = rst ? RESET_PC :
                           (r_state == DROP) ? r_drop_addr : r_fetch_pc;
    assign bus.valid_IF  = ~w_empty;
    assign bus.IR_IF     = w_empty ? c_nop : w_head.inst;
    assign bus.PC_IF     = w_pc_out;
    assign bus.PC4_IF    = w_pc_out + 32'd4;

endmodule

`default_nettype wire

// File: tb/tb_if_stage.sv
// ============================================================================
// Module   : tb_if_stage
// Brief    : Directed bench for if_stage with variable-latency imem and scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_if_stage;
    import if_stage_pkg::*;

    logic clk;
    logic rst;
    int   lat;
    int   wcnt;
    int   n_checks;
    int   n_pass;
    fq_entry_t exp_q[$];
    fq_entry_t e;

    if_stage_if bus ();

    if_stage #(
        .RESET_PC (32'h0000_0000),
        .FQ_DEPTH (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        return {a[15:0], 16'h0013};
    endfunction

    // imem: acks once the request has been held for lat cycles
    assign bus.imem_ack   = bus.imem_req && (wcnt >= lat);
    assign bus.imem_rdata = mem_word(bus.imem_addr);

    always @(posedge clk) begin
        if (rst)                                 wcnt <= 0;
        else if (bus.imem_req && !bus.imem_ack)  wcnt <= wcnt + 1;
        else                                     wcnt <= 0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, expv);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] pc, input logic [31:0] inst);
        exp_q.push_back('{pc: pc, inst: inst});
    endtask

    // Monitor: every instruction ID actually takes on the correct path
    always @(negedge clk) begin
        if (!rst && bus.valid_IF && !bus.stall_ID && !bus.br_taken_EX) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL sb_extra: got pc %h expected no instruction", bus.PC_IF);
            end else begin
                e = exp_q.pop_front();
                chk("sb_pc",  bus.PC_IF,  e.pc);
                chk("sb_ir",  bus.IR_IF,  e.inst);
                chk("sb_pc4", bus.PC4_IF, e.pc + 32'd4);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst = 1'b1;
        lat = 0;
        bus.stall_ID     = 1'b0;
        bus.br_taken_EX  = 1'b0;
        bus.br_target_EX = 32'h0;

        step(); step();
        chk("rst_req",   {31'h0, bus.imem_req}, 32'h0);
        chk("rst_addr",  bus.imem_addr,         32'h0);
        chk("rst_valid", {31'h0, bus.valid_IF}, 32'h0);
        chk("rst_ir",    bus.IR_IF,             32'h0000_0013);
        chk("rst_pc",    bus.PC_IF,             32'h0);
        chk("rst_pc4",   bus.PC4_IF,            32'h4);

        push_exp(32'h0000_0000, 32'h0050_0093);
        push_exp(32'h0000_0004, 32'h0004_0013);
        push_exp(32'h0000_0008, 32'h0008_0013);
        push_exp(32'h0000_000C, 32'h000C_0013);
        push_exp(32'h0000_0010, 32'h0010_0013);
        push_exp(32'h0000_0014, 32'h0014_0013);
        push_exp(32'h0000_0204, 32'h0204_0013);
        push_exp(32'h0000_0300, 32'h0300_0013);
        push_exp(32'hFFFF_FFFC, 32'hFFFC_0013);
        push_exp(32'h0000_0000, 32'h0050_0093);

        // zero-wait streaming
        rst = 1'b0; #1;
        chk("c1_req",  {31'h0, bus.imem_req}, 32'h1);
        chk("c1_addr", bus.imem_addr,         32'h0);
        step();
        chk("c2_valid", {31'h0, bus.valid_IF}, 32'h1);
        chk("c2_ir",    bus.IR_IF,             32'h0050_0093);
        chk("c2_pc",    bus.PC_IF,             32'h0);
        chk("c2_pc4",   bus.PC4_IF,            32'h4);
        chk("c2_addr",  bus.imem_addr,         32'h4);
        step(); chk("c3_addr", bus.imem_addr, 32'h8);
        step(); chk("c4_addr", bus.imem_addr, 32'hC);

        // stall 5 cycles: queue fills, request drops, outputs hold
        step(); bus.stall_ID = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("stall_req", {31'h0, bus.imem_req}, 32'h0);
            chk("stall_pc",  bus.PC_IF,             32'hC);
            chk("stall_ir",  bus.IR_IF,             32'h000C_0013);
        end
        step(); bus.stall_ID = 1'b0; #1;
        chk("rel_req", {31'h0, bus.imem_req}, 32'h0);
        step();
        chk("rel2_req",  {31'h0, bus.imem_req}, 32'h1);
        chk("rel2_addr", bus.imem_addr,         32'h14);
        chk("rel2_pc",   bus.PC_IF,             32'h10);
        step(); chk("rel3_pc", bus.PC_IF, 32'h14);

        // redirect with a full queue being popped (no request outstanding)
        step(); bus.stall_ID = 1'b1;
        step();
        step(); bus.stall_ID = 1'b0; bus.br_taken_EX = 1'b1; bus.br_target_EX = 32'h0000_0205; #1;
        chk("fullbr_req", {31'h0, bus.imem_req}, 32'h0);
        step(); bus.br_taken_EX = 1'b0; #1;
        chk("fullbr_valid", {31'h0, bus.valid_IF}, 32'h0);
        chk("fullbr_addr",  bus.imem_addr,         32'h204);
        step(); chk("fullbr_pc", bus.PC_IF, 32'h204);

        // redirect in the same cycle as ack and pop
        step(); bus.br_taken_EX = 1'b1; bus.br_target_EX = 32'h0000_0300; #1;
        chk("ackbr_ack", {31'h0, bus.imem_ack}, 32'h1);
        chk("ackbr_pc",  bus.PC_IF,             32'h208);
        step(); bus.br_taken_EX = 1'b0; #1;
        chk("ackbr_valid", {31'h0, bus.valid_IF}, 32'h0);
        chk("ackbr_addr",  bus.imem_addr,         32'h300);
        step(); chk("ackbr_pc2", bus.PC_IF, 32'h300);

        // PC wrap at the top of the address space
        step(); bus.stall_ID = 1'b1;
        step(); bus.stall_ID = 1'b0; bus.br_taken_EX = 1'b1; bus.br_target_EX = 32'hFFFF_FFFE;
        step(); bus.br_taken_EX = 1'b0; #1;
        chk("wrap_addr0", bus.imem_addr, 32'hFFFF_FFFC);
        step();
        chk("wrap_pc",   bus.PC_IF,     32'hFFFF_FFFC);
        chk("wrap_pc4",  bus.PC4_IF,    32'h0);
        chk("wrap_addr", bus.imem_addr, 32'h0);
        step(); chk("wrap_pc2", bus.PC_IF, 32'h0);
        step(); bus.stall_ID = 1'b1;
        step(); chk("sb_drain1", 32'(exp_q.size()), 32'h0);

        // 3-cycle imem, redirect while 0x10 is pending
        rst = 1'b1; lat = 3;
        step(); step();
        push_exp(32'h0000_0000, 32'h0050_0093);
        push_exp(32'h0000_0004, 32'h0004_0013);
        push_exp(32'h0000_0008, 32'h0008_0013);
        push_exp(32'h0000_000C, 32'h000C_0013);
        push_exp(32'h0000_0100, 32'h0100_0013);
        bus.stall_ID = 1'b0; rst = 1'b0; #1;
        for (int k = 0; k < 100 && !(bus.imem_req && bus.imem_addr == 32'h10); k++) step();
        chk("drop_seen", bus.imem_addr, 32'h10);
        step(); bus.br_taken_EX = 1'b1; bus.br_target_EX = 32'h0000_0103; #1;
        chk("drop_noack", {31'h0, bus.imem_ack}, 32'h0);
        step(); bus.br_taken_EX = 1'b0; #1;
        chk("drop_req",  {31'h0, bus.imem_req}, 32'h1);
        chk("drop_addr", bus.imem_addr,         32'h10);
        for (int k = 0; k < 20 && !(bus.imem_ack && bus.imem_addr == 32'h100); k++) begin
            chk("drop_valid", {31'h0, bus.valid_IF}, 32'h0);
            step();
        end
        chk("drop_newaddr", bus.imem_addr, 32'h100);
        step();
        chk("drop_valid1", {31'h0, bus.valid_IF}, 32'h1);
        chk("drop_pc",     bus.PC_IF,             32'h100);
        chk("drop_ir",     bus.IR_IF,             32'h0100_0013);

        // reset while in DROP
        step(); bus.stall_ID = 1'b1; bus.br_taken_EX = 1'b1; bus.br_target_EX = 32'h0000_0400; #1;
        chk("drop2_noack", {31'h0, bus.imem_ack}, 32'h0);
        step(); bus.br_taken_EX = 1'b0; #1;
        chk("drop2_addr", bus.imem_addr, 32'h104);
        rst = 1'b1; #1;
        chk("rst2_req", {31'h0, bus.imem_req}, 32'h0);
        step(); rst = 1'b0; #1;
        chk("rst2_req1",  {31'h0, bus.imem_req}, 32'h1);
        chk("rst2_addr",  bus.imem_addr,         32'h0);
        chk("rst2_valid", {31'h0, bus.valid_IF}, 32'h0);
        chk("sb_drain2", 32'(exp_q.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
